traffic_timer: RTL and testbench

Programmable interval timer serving the traffic-light controller FSM. It accepts the FSM's `start_timer`/`interval` request and returns a one-cycle `expired` pulse after the selected number of seconds, counting from an internal 1 Hz enable. It holds the run-time programmable durations tBASE, tEXT and tYEL, and sits between the synchronizer block and the FSM.

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/one_hz_divider.sv | 37 +++
 rtl/traffic_timer.sv | 116 +++++++++++
 tb/tb_traffic_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light interval timer.
// Interval codes, parameter selects, timer states and reset durations.
package traffic_pkg;

    typedef enum logic [1:0] {
        TB   = 2'b00,
        TE   = 2'b01,
        TY   = 2'b10,
        TBX2 = 2'b11
    } interval_e;

    typedef enum logic [1:0] {
        SEL_TBASE = 2'b00,
        SEL_TEXT  = 2'b01,
        SEL_TYEL  = 2'b10,
        SEL_NONE  = 2'b11
    } param_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_COUNT  = 2'b10,
        ST_EXPIRE = 2'b11
    } tstate_e;

    localparam int TBASE_DEF = 6;
    localparam int TEXT_DEF  = 3;
    localparam int TYEL_DEF  = 2;

endpackage

// File: rtl/one_hz_divider.sv
// Free-running clock divider producing a one-cycle tick per second.
// A clear restarts the second so a fresh interval is timed in full.
module one_hz_divider #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic clear,
    output logic one_hz
);

    localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_HZ - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    assign one_hz = (div_q == LAST);

    // Next divider value: clear wins, otherwise count and wrap on the tick.
    always_comb begin
        div_d = div_q + 1'b1;
        if (clear || one_hz) begin
            div_d = '0;
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/traffic_timer.sv
// Programmable interval timer for the traffic-light controller FSM.
// Holds tBASE/tEXT/tYEL and pulses expired after the chosen interval.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int VALW      = 4,
    parameter int DEF_TBASE = TBASE_DEF,
    parameter int DEF_TEXT  = TEXT_DEF,
    parameter int DEF_TYEL  = TYEL_DEF
) (
    input  logic            clk,
    input  logic            Reset_n,
    input  logic            start_timer,
    input  logic [1:0]      interval,
    input  logic            Reset_Sync,
    input  logic            Prog_Sync,
    input  logic [1:0]      Time_Param_Sel,
    input  logic [VALW-1:0] Time_Value,
    output logic            expired,
    output logic            one_hz,
    output logic [VALW:0]   Remaining
);

    logic [VALW-1:0] tbase_q;
    logic [VALW-1:0] text_q;
    logic [VALW-1:0] tyel_q;
    logic [VALW:0]   dur_d;
    logic [VALW:0]   count_q;
    tstate_e         state_q;
    logic            expired_q;
    logic            restart;
    logic            div_clear;

    assign restart   = Reset_Sync | Prog_Sync;
    assign div_clear = (state_q == ST_LOAD);
    assign expired   = expired_q;
    assign Remaining = (state_q == ST_COUNT) ? count_q : '0;

    one_hz_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_div (
        .clk     (clk),
        .Reset_n (Reset_n),
        .clear   (div_clear),
        .one_hz  (one_hz)
    );

    // Program a duration register; a zero duration is ignored.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tbase_q <= VALW'(DEF_TBASE);
            text_q  <= VALW'(DEF_TEXT);
            tyel_q  <= VALW'(DEF_TYEL);
        end else if (Prog_Sync && (Time_Value != '0)) begin
            unique case (param_sel_e'(Time_Param_Sel))
                SEL_TBASE: tbase_q <= Time_Value;
                SEL_TEXT:  text_q  <= Time_Value;
                SEL_TYEL:  tyel_q  <= Time_Value;
                default:   ;
            endcase
        end
    end

    // Decode the interval code into seconds; double tBASE needs the extra bit.
    always_comb begin
        dur_d = {1'b0, tbase_q};
        unique case (interval_e'(interval))
            TB:      dur_d = {1'b0, tbase_q};
            TE:      dur_d = {1'b0, text_q};
            TY:      dur_d = {1'b0, tyel_q};
            TBX2:    dur_d = {tbase_q, 1'b0};
            default: dur_d = {1'b0, tbase_q};
        endcase
    end

    // Timer FSM; a button restart overrides everything, including expiry.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (restart) begin
                state_q <= ST_LOAD;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_timer) begin
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        count_q <= dur_d;
                        state_q <= ST_COUNT;
                    end
                    ST_COUNT: begin
                        if (one_hz) begin
                            count_q <= count_q - 1'b1;
                            if (count_q == (VALW+1)'(1)) begin
                                state_q   <= ST_EXPIRE;
                                expired_q <= 1'b1;
                            end
                        end
                    end
                    ST_EXPIRE: begin
                        state_q <= start_timer ? ST_LOAD : ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer with CLK_HZ = 4.
// Latencies and Remaining values are hand-derived from N*4+1.
module tb_traffic_timer;

    localparam int HZ = 4;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          start_timer = 1'b0;
    logic [1:0]    interval = 2'b00;
    logic          Reset_Sync = 1'b0;
    logic          Prog_Sync = 1'b0;
    logic [1:0]    Time_Param_Sel = 2'b00;
    logic [VW-1:0] Time_Value = '0;
    logic          expired;
    logic          one_hz;
    logic [VW:0]   Remaining;

    int checks = 0;
    int errors = 0;

    traffic_timer #(
        .CLK_HZ (HZ),
        .VALW   (VW)
    ) dut (
        .clk            (clk),
        .Reset_n        (Reset_n),
        .start_timer    (start_timer),
        .interval       (interval),
        .Reset_Sync     (Reset_Sync),
        .Prog_Sync      (Prog_Sync),
        .Time_Param_Sel (Time_Param_Sel),
        .Time_Value     (Time_Value),
        .expired        (expired),
        .one_hz         (one_hz),
        .Remaining      (Remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the LOAD cycle; times the interval and checks Remaining.
    task automatic run_iv(input string tag, input int n);
        int k;
        for (k = 1; k <= n * HZ + 10; k++) begin
            step();
            if (expired) break;
            check({tag, " rem"}, int'(Remaining), n - (k - 1) / HZ);
        end
        check({tag, " lat"}, k, n * HZ + 1);
        check({tag, " rem@exp"}, int'(Remaining), 0);
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        #2;
        check("rst expired", int'(expired), 0);
        check("rst one_hz", int'(one_hz), 0);
        check("rst rem", int'(Remaining), 0);
        @(posedge clk);
        #2;
        Reset_n = 1'b1;
        start_timer = 1'b1;
        interval = 2'b00;
        step();
        check("load rem", int'(Remaining), 0);
        run_iv("tbase", 6);

        interval = 2'b11;
        step();
        check("pulse width", int'(expired), 0);
        run_iv("x2", 12);
        interval = 2'b10;
        step();
        check("b2b expired", int'(expired), 0);
        run_iv("tyel", 2);

        start_timer = 1'b0;
        step();
        check("idle rem", int'(Remaining), 0);
        repeat (3) step();
        check("idle expired", int'(expired), 0);

        Prog_Sync = 1'b1;
        Time_Param_Sel = 2'b01;
        Time_Value = 4'd7;
        interval = 2'b01;
        start_timer = 1'b1;
        step();
        Prog_Sync = 1'b0;
        run_iv("text7", 7);

        Prog_Sync = 1'b1;
        Time_Value = 4'd0;
        step();
        Prog_Sync = 1'b0;
        check("prog0 expired", int'(expired), 0);
        run_iv("text0kept", 7);

        Prog_Sync = 1'b1;
        Time_Param_Sel = 2'b11;
        Time_Value = 4'd9;
        interval = 2'b00;
        step();
        Prog_Sync = 1'b0;
        run_iv("selnone", 6);

        step();
        repeat (14) step();
        check("rsync rem", int'(Remaining), 3);
        Reset_Sync = 1'b1;
        interval = 2'b11;
        step();
        Reset_Sync = 1'b0;
        check("rsync expired", int'(expired), 0);
        check("rsync rem0", int'(Remaining), 0);
        run_iv("rsync", 12);

        interval = 2'b00;
        step();
        repeat (24) step();
        check("coll rem", int'(Remaining), 1);
        check("coll tick", int'(one_hz), 1);
        Prog_Sync = 1'b1;
        Time_Param_Sel = 2'b11;
        interval = 2'b10;
        step();
        Prog_Sync = 1'b0;
        check("coll expired", int'(expired), 0);
        check("coll rem0", int'(Remaining), 0);
        run_iv("coll", 2);

        interval = 2'b00;
        step();
        repeat (8) step();
        check("pre rst rem", int'(Remaining), 5);
        check("pre rst tick", int'(one_hz), 1);
        #2 Reset_n = 1'b0;
        #1;
        check("async expired", int'(expired), 0);
        check("async one_hz", int'(one_hz), 0);
        check("async rem", int'(Remaining), 0);
        @(negedge clk);
        Reset_n = 1'b1;
        interval = 2'b01;
        step();
        run_iv("def text", 3);
        interval = 2'b10;
        step();
        run_iv("def tyel", 2);
        interval = 2'b00;
        step();
        run_iv("def tbase", 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
